// File: rtl/sticker_color_avg.sv
// Averages RGB565 colour over a 3x3 grid of sticker windows in one frame and classifies each window.
// Optional macro STICKER_DEBUG_AVG_EN adds a per-sticker RGB565 average readback port.
module sticker_color_avg #(
  parameter int IMG_W     = 160,
  parameter int IMG_H     = 120,
  parameter int WIN_LOG2  = 3,
  parameter int GRID_X0   = 40,
  parameter int GRID_Y0   = 20,
  parameter int GRID_STEP = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture,
  input  logic        frame_start,
  input  logic        line_end,
  input  logic        pix_valid,
  input  logic [15:0] pix_data,
  input  logic        frame_done,
  output logic        busy,
  output logic [26:0] colors,
  output logic        colors_valid
`ifdef STICKER_DEBUG_AVG_EN
  ,
  input  logic [3:0]  dbg_sel,
  output logic [15:0] dbg_avg
`endif
);

  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam int SH  = 2 * WIN_LOG2;
  localparam int WIN = 2 ** WIN_LOG2;
  localparam int RBW = 5 + SH;
  localparam int GW  = 6 + SH;

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_ACC, S_CLASS, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [3:0]      idx_q, idx_d;
  logic [RBW-1:0]  acc_r_q [9];
  logic [RBW-1:0]  acc_r_d [9];
  logic [GW-1:0]   acc_g_q [9];
  logic [GW-1:0]   acc_g_d [9];
  logic [RBW-1:0]  acc_b_q [9];
  logic [RBW-1:0]  acc_b_d [9];
  logic [26:0]     codes_q, codes_d;
  logic [26:0]     colors_q, colors_d;
  logic            colors_valid_q, colors_valid_d;
  logic            win_hit;
  logic [3:0]      win_idx;
  logic            clr;
  logic [4:0]      avg_r5;
  logic [5:0]      avg_g6;
  logic [4:0]      avg_b5;
  logic [2:0]      cls_code;
`ifdef STICKER_DEBUG_AVG_EN
  logic [15:0]     avg_q [9];
  logic [15:0]     avg_d [9];
`endif

  function automatic logic [2:0] classify(input logic [4:0] r5, input logic [5:0] g6,
                                          input logic [4:0] b5);
    logic [7:0] r8, g8, b8;
    logic [8:0] r9, g9, b9;
    r8 = {r5, r5[4:2]};
    g8 = {g6, g6[5:4]};
    b8 = {b5, b5[4:2]};
    r9 = {1'b0, r8};
    g9 = {1'b0, g8};
    b9 = {1'b0, b8};
    if (r8 > 8'd160 && g8 > 8'd160 && b8 > 8'd160) return 3'd0;
    if (r8 > 8'd150 && g8 > 8'd150 && b8 < 8'd100) return 3'd1;
    if (r8 > 8'd150 && g8 >= 8'd80 && g8 <= 8'd150 && b8 < 8'd80) return 3'd3;
    if (r8 > 8'd120 && g8 < 8'd80) return 3'd2;
    if (g9 > r9 + 9'd30 && g9 > b9 + 9'd30) return 3'd4;
    if (b9 > r9 + 9'd30 && b8 > g8) return 3'd5;
    return 3'd7;
  endfunction

  // Which sticker window, if any, owns the current pixel position
  always_comb begin
    win_hit = 1'b0;
    win_idx = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (32'(col_q) >= 32'(GRID_X0 + c * GRID_STEP) &&
            32'(col_q) <  32'(GRID_X0 + c * GRID_STEP + WIN) &&
            32'(row_q) >= 32'(GRID_Y0 + r * GRID_STEP) &&
            32'(row_q) <  32'(GRID_Y0 + r * GRID_STEP + WIN)) begin
          win_hit = 1'b1;
          win_idx = 4'(3 * r + c);
        end
      end
    end
  end

  assign avg_r5   = acc_r_q[idx_q][RBW-1:SH];
  assign avg_g6   = acc_g_q[idx_q][GW-1:SH];
  assign avg_b5   = acc_b_q[idx_q][RBW-1:SH];
  assign cls_code = classify(avg_r5, avg_g6, avg_b5);

  always_comb begin
    state_d        = state_q;
    col_d          = col_q;
    row_d          = row_q;
    idx_d          = idx_q;
    acc_r_d        = acc_r_q;
    acc_g_d        = acc_g_q;
    acc_b_d        = acc_b_q;
    codes_d        = codes_q;
    colors_d       = colors_q;
    colors_valid_d = 1'b0;
    clr            = 1'b0;
`ifdef STICKER_DEBUG_AVG_EN
    avg_d          = avg_q;
`endif
    case (state_q)
      S_IDLE: if (capture) state_d = S_ARM;
      S_ARM: begin
        if (!capture) begin
          state_d = S_IDLE;
        end else if (frame_start) begin
          state_d = S_ACC;
          clr     = 1'b1;
        end
      end
      S_ACC: begin
        // A fresh frame_start means the previous frame was abandoned
        if (frame_start) begin
          clr = 1'b1;
        end else begin
          if (pix_valid) begin
            if (win_hit) begin
              acc_r_d[win_idx] = acc_r_q[win_idx] + RBW'(pix_data[15:11]);
              acc_g_d[win_idx] = acc_g_q[win_idx] + GW'(pix_data[10:5]);
              acc_b_d[win_idx] = acc_b_q[win_idx] + RBW'(pix_data[4:0]);
            end
            if (col_q != CW'(IMG_W - 1)) col_d = col_q + 1'b1;
          end
          if (line_end) begin
            col_d = '0;
            if (row_q != RW'(IMG_H - 1)) row_d = row_q + 1'b1;
          end
          if (frame_done) begin
            state_d = S_CLASS;
            idx_d   = '0;
          end
        end
      end
      S_CLASS: begin
        codes_d[3*int'(idx_q) +: 3] = cls_code;
`ifdef STICKER_DEBUG_AVG_EN
        avg_d[idx_q] = {avg_r5, avg_g6, avg_b5};
`endif
        if (idx_q == 4'd8) state_d = S_DONE;
        else idx_d = idx_q + 1'b1;
      end
      S_DONE: begin
        colors_d       = codes_q;
        colors_valid_d = 1'b1;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (clr) begin
      col_d = '0;
      row_d = '0;
      for (int k = 0; k < 9; k++) begin
        acc_r_d[k] = '0;
        acc_g_d[k] = '0;
        acc_b_d[k] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      col_q          <= '0;
      row_q          <= '0;
      idx_q          <= '0;
      codes_q        <= 27'h7FFFFFF;
      colors_q       <= 27'h7FFFFFF;
      colors_valid_q <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        acc_r_q[k] <= '0;
        acc_g_q[k] <= '0;
        acc_b_q[k] <= '0;
`ifdef STICKER_DEBUG_AVG_EN
        avg_q[k]   <= '0;
`endif
      end
    end else begin
      state_q        <= state_d;
      col_q          <= col_d;
      row_q          <= row_d;
      idx_q          <= idx_d;
      codes_q        <= codes_d;
      colors_q       <= colors_d;
      colors_valid_q <= colors_valid_d;
      acc_r_q        <= acc_r_d;
      acc_g_q        <= acc_g_d;
      acc_b_q        <= acc_b_d;
`ifdef STICKER_DEBUG_AVG_EN
      avg_q          <= avg_d;
`endif
    end
  end

  assign busy         = (state_q == S_ARM) || (state_q == S_ACC) || (state_q == S_CLASS);
  assign colors       = colors_q;
  assign colors_valid = colors_valid_q;
`ifdef STICKER_DEBUG_AVG_EN
  assign dbg_avg      = (dbg_sel <= 4'd8) ? avg_q[dbg_sel] : 16'h0000;
`endif

endmodule

// File: doc/sticker_color_avg.md
Name: sticker_color_avg

Overview:
- Downstream consumer of the camera capture stage.
- Takes the RGB565 pixel stream of one captured frame and averages colour over a 3x3 grid of square windows, one per cube sticker.
- At frame end, classifies each window into one of six cube colours and presents a 27-bit face result to the cube-state logic.

Parameters:
IMG_W, 160, active pixels per line; column counter saturates at IMG_W-1
IMG_H, 120, active lines per frame; row counter saturates at IMG_H-1
WIN_LOG2, 3, window side = 2**WIN_LOG2 pixels (8x8 = 64 samples)
GRID_X0, 40, left column of sticker column 0
GRID_Y0, 20, top row of sticker row 0
GRID_STEP, 32, pitch between window origins, both axes

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
capture  in  1  level; arms capture of the next frame while IDLE
frame_start  in  1  one-cycle pulse at start of frame (Vsyn end)
line_end  in  1  one-cycle pulse after last pixel of a line
pix_valid  in  1  pix_data valid this cycle
pix_data  in  16  RGB565 pixel {R[4:0],G[5:0],B[4:0]}
frame_done  in  1  one-cycle pulse, frame complete
busy  out  1  high in ARM, ACC, CLASS
colors  out  27  sticker k (k=3*row+col) code at [3k+2:3k]
colors_valid  out  1  one-cycle pulse, colors updated

Behaviour:
- Reset (rst=0, async):
  - State = IDLE.
  - Counters and accumulators = 0.
  - colors = 27'h7FFFFFF (all unknown); colors_valid = 0; busy = 0.
- States:
  - IDLE: capture=1 -> ARM.
  - ARM: frame_start -> ACC. Clear all accumulators and set col=row=0.
  - ACC:
    - pix_valid: add pixel to the owning window's accumulators if inside one, then col++ (saturating).
    - line_end: col=0, row++ (saturating).
    - frame_start in ACC: aborted frame. Clear accumulators and counters, stay in ACC.
    - frame_done -> CLASS, idx=0.
  - CLASS: one sticker per clock, idx 0..8. After idx=8 -> DONE.
  - DONE:
    - colors_valid=1 for exactly one cycle; colors carries all nine new codes in that same cycle.
    - Then -> IDLE (re-arms on capture).
- Window membership: sticker (r,c) covers col in [GRID_X0+c*GRID_STEP, +2**WIN_LOG2) and row in [GRID_Y0+r*GRID_STEP, +2**WIN_LOG2).
- Accumulator widths (no overflow possible):
  - R, B: 5+2*WIN_LOG2 bits.
  - G: 6+2*WIN_LOG2 bits.
- Average = accumulator >> (2*WIN_LOG2). Expand to 8 bits:
  - r8 = {R5, R5[4:2]}
  - g8 = {G6, G6[5:4]}
  - b8 = {B5, B5[4:2]}
- Classification, first match wins (unsigned compares, sums widened to 9 bits):
  - W=0: r8>160 && g8>160 && b8>160
  - Y=1: r8>150 && g8>150 && b8<100
  - O=3: r8>150 && g8>=80 && g8<=150 && b8<80
  - R=2: r8>120 && g8<80
  - G=4: g8>r8+30 && g8>b8+30
  - B=5: b8>r8+30 && b8>g8
  - else unknown=7
- Latency: colors_valid asserts exactly 10 clocks after the cycle frame_done is sampled in ACC.
- Input handling:
  - pix_valid together with frame_done: the pixel is accumulated.
  - pix_valid together with line_end: the pixel is accumulated at the current row, then col resets.
  - pix_valid, line_end, frame_start, frame_done are ignored in IDLE, CLASS and DONE. frame_done in ARM is ignored.
- capture dropped in ARM -> IDLE. capture dropped in ACC/CLASS: operation completes.
- Reset mid-ACC or mid-CLASS: no colors_valid; colors returns to the reset value.
- colors holds its value between updates.

Optional Feature:
- Macro: STICKER_DEBUG_AVG_EN.
- Defined:
  - Adds ports dbg_sel in 4 and dbg_avg out 16.
  - dbg_avg = RGB565 average of sticker dbg_sel, latched during CLASS.
  - dbg_sel>8 gives 16'h0000; reset value 16'h0000.
- Undefined: ports and average storage are absent; all other behaviour is identical.

Test Plan:
- Full 160x120 frame of 16'hFFFF, then frame_done -> colors_valid exactly 10 clocks later, colors=27'h0000000 (all W), busy low afterwards.
- Frame of 16'hF800 -> every field 3'd2 (R), colors=27'h2492492. Frame of 16'h07E0 -> every field 3'd4 (G).
- Frame of 16'hFFE0 everywhere except sticker 4 window (cols 72-79, rows 52-59) = 16'h001F -> field 4 = 3'd5, all others 3'd1.
- frame_start pulsed at row 60 of a red frame, followed by a full white frame -> single colors_valid, all W; no contribution from the aborted frame.
- rst low during CLASS (idx=4) -> no colors_valid, colors=27'h7FFFFFF. Next capture+frame completes normally.
- Pixels outside windows set to 16'h001F, windows 16'hFFFF; pixel with pix_valid and frame_done in the same cycle at (47,91) -> all W. With STICKER_DEBUG_AVG_EN: dbg_sel=0 gives dbg_avg=16'hFFFF; dbg_sel=9 gives 0.
